// File: rtl/btn_event.sv
// Decodes a debounced button level into single-cycle press/release/click/
// double-click/long-press/auto-repeat pulses, using a prescaled 1 ms timebase.
module btn_event #(
  parameter int TICK_DIV  = 100000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int DCLICK_MS = 300,
  parameter int CW        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_ok,
  output logic held,
  output logic press_p,
  output logic release_p,
  output logic click_p,
  output logic dbl_p,
  output logic long_p,
  output logic rpt_p
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] LONG_V   = CW'(LONG_MS);
  localparam logic [CW-1:0] DCLICK_V = CW'(DCLICK_MS);
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_MS - 1);

  typedef enum logic [2:0] {IDLE, PRESS, LONG, WAIT, PRESS2} state_t;

  logic          s1, s, sp;
  logic          rise, fall, tick;
  logic [PW-1:0] pre;
  logic [CW-1:0] ms, ms_next, rc;
  logic          long_hit, dclick_hit;
  state_t        state;

  // NOTE: non-blocking assignments make every flop sample the pre-edge value,
  // so this chain is a true 2-FF synchronizer plus edge register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s  <= 1'b0;
      sp <= 1'b0;
    end else begin
      s1 <= btn_ok;
      s  <= s1;
      sp <= s;
    end
  end

  assign held = s;
  assign rise = s & ~sp;
  assign fall = ~s & sp;
  assign tick = (pre == PRE_LAST);

  // ms saturates at all-ones; the timeouts fire on the tick that brings ms to the limit
  assign ms_next    = (ms == '1) ? ms : ms + CW'(1);
  assign long_hit   = tick && (ms_next == LONG_V);
  assign dclick_hit = tick && (ms_next == DCLICK_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      ms  <= '0;
    end else if (rise || fall) begin
      pre <= '0;
      ms  <= '0;
    end else if (tick) begin
      pre <= '0;
      ms  <= ms_next;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rc        <= '0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      click_p   <= 1'b0;
      dbl_p     <= 1'b0;
      long_p    <= 1'b0;
      rpt_p     <= 1'b0;
    end else begin
      press_p   <= 1'b0;
      release_p <= 1'b0;
      click_p   <= 1'b0;
      dbl_p     <= 1'b0;
      long_p    <= 1'b0;
      rpt_p     <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            press_p <= 1'b1;
            state   <= PRESS;
          end
        end
        PRESS, PRESS2: begin
          // an edge beats a timeout landing in the same cycle
          if (fall) begin
            release_p <= 1'b1;
            state     <= (state == PRESS) ? WAIT : IDLE;
          end else if (long_hit) begin
            long_p <= 1'b1;
            rc     <= '0;
            state  <= LONG;
          end
        end
        LONG: begin
          if (fall) begin
            release_p <= 1'b1;
            state     <= IDLE;
          end else if (tick) begin
            if (rc == RPT_LAST) begin
              rpt_p <= 1'b1;
              rc    <= '0;
            end else begin
              rc <= rc + CW'(1);
            end
          end
        end
        WAIT: begin
          if (rise) begin
            press_p <= 1'b1;
            dbl_p   <= 1'b1;
            state   <= PRESS2;
          end else if (dclick_hit) begin
            click_p <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event.sv
// Randomized and directed bench for btn_event against a cycle-time event model
// that works from edge timestamps rather than prescaler/counter state.
module tb_btn_event;

  localparam int TICK_DIV  = 4;
  localparam int LONG_MS   = 10;
  localparam int REPEAT_MS = 3;
  localparam int DCLICK_MS = 5;
  localparam int LONG_CYC  = TICK_DIV * LONG_MS;
  localparam int RPT_CYC   = TICK_DIV * REPEAT_MS;
  localparam int DCL_CYC   = TICK_DIV * DCLICK_MS;

  logic clk = 1'b0;
  logic rst, btn_ok;
  logic held, press_p, release_p, click_p, dbl_p, long_p, rpt_p;
  logic [6:0] outs;

  typedef enum {M_IDLE, M_HELD, M_HELD2, M_LONG, M_GAP} mode_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc, t_edge, t_long;
  int cnt[7];
  logic [3:0] hist;
  mode_t mode;

  btn_event #(
    .TICK_DIV(TICK_DIV), .LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS),
    .DCLICK_MS(DCLICK_MS), .CW(16)
  ) dut (
    .clk(clk), .rst(rst), .btn_ok(btn_ok), .held(held),
    .press_p(press_p), .release_p(release_p), .click_p(click_p),
    .dbl_p(dbl_p), .long_p(long_p), .rpt_p(rpt_p)
  );

  always #5 clk = ~clk;

  // bit order: held, press, release, click, dbl, long, rpt
  assign outs = {held, press_p, release_p, click_p, dbl_p, long_p, rpt_p};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < 7; i++) cnt[i] = 0;
  endtask

  // One clock: drive at negedge, then compare registered outputs just after posedge.
  task automatic step(input logic b, input logic r);
    logic [6:0] exp;
    logic lvl, prev;
    @(negedge clk);
    rst    = r;
    btn_ok = b;
    if (r) begin
      #1;
      check("rst_async", 32'(outs), 32'd0);
    end
    @(posedge clk);
    #1;
    cyc++;
    exp = '0;
    if (r) begin
      hist = '0;
      mode = M_IDLE;
    end else begin
      // hist[k] = btn_ok sampled k edges ago; the decoder acts on the level two edges back
      hist   = {hist[2:0], b};
      exp[6] = hist[1];
      lvl    = hist[2];
      prev   = hist[3];
      case (mode)
        M_IDLE:
          if (lvl && !prev) begin
            exp[5] = 1'b1;
            mode   = M_HELD;
          end
        M_HELD, M_HELD2:
          if (!lvl && prev) begin
            exp[4] = 1'b1;
            mode   = (mode == M_HELD) ? M_GAP : M_IDLE;
          end else if (cyc - t_edge == LONG_CYC) begin
            exp[1] = 1'b1;
            mode   = M_LONG;
            t_long = cyc;
          end
        M_LONG:
          if (!lvl && prev) begin
            exp[4] = 1'b1;
            mode   = M_IDLE;
          end else if (cyc > t_long && (cyc - t_long) % RPT_CYC == 0) begin
            exp[0] = 1'b1;
          end
        M_GAP:
          if (lvl && !prev) begin
            exp[5] = 1'b1;
            exp[2] = 1'b1;
            mode   = M_HELD2;
          end else if (cyc - t_edge == DCL_CYC) begin
            exp[3] = 1'b1;
            mode   = M_IDLE;
          end
        default: mode = M_IDLE;
      endcase
      if (lvl != prev) t_edge = cyc;
    end
    check("outs", 32'(outs), 32'(exp));
    for (int i = 0; i < 7; i++) cnt[i] += int'(outs[i]);
  endtask

  task automatic run(input logic b, input int k);
    for (int i = 0; i < k; i++) step(b, 1'b0);
  endtask

  initial begin
    int dur;
    logic lv;
    rst    = 1'b1;
    btn_ok = 1'b1;
    hist   = '0;
    mode   = M_IDLE;
    cyc    = 0;
    t_edge = 0;
    t_long = 0;
    clear_cnt();

    // button held through reset: fresh press three edges after release of rst
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    clear_cnt();
    run(1'b1, 2);
    check("rst_press_early", 32'(cnt[5]), 32'd0);
    run(1'b1, 1);
    check("rst_press", 32'(cnt[5]), 32'd1);
    check("rst_held", 32'(held), 32'd1);
    run(1'b0, 30);

    // short click: 8 ms press
    clear_cnt();
    run(1'b1, 32);
    run(1'b0, 40);
    check("click_cnt", 32'(cnt[3]), 32'd1);
    check("click_nodbl", 32'(cnt[2]), 32'd0);
    check("click_nolong", 32'(cnt[1]), 32'd0);
    check("click_rel", 32'(cnt[4]), 32'd1);

    // double click: 2 ms on / 2 ms off / 2 ms on
    clear_cnt();
    run(1'b1, 8);
    run(1'b0, 8);
    run(1'b1, 8);
    run(1'b0, 40);
    check("dbl_cnt", 32'(cnt[2]), 32'd1);
    check("dbl_noclick", 32'(cnt[3]), 32'd0);
    check("dbl_press", 32'(cnt[5]), 32'd2);

    // long press with auto-repeat: 20 ms hold
    clear_cnt();
    run(1'b1, 80);
    run(1'b0, 30);
    check("long_cnt", 32'(cnt[1]), 32'd1);
    check("rpt_cnt", 32'(cnt[0]), 32'd3);
    check("long_noclick", 32'(cnt[3]), 32'd0);
    check("long_rel", 32'(cnt[4]), 32'd1);

    // second rise lands on the very tick that would time out the gap
    clear_cnt();
    run(1'b1, 8);
    run(1'b0, 20);
    run(1'b1, 8);
    run(1'b0, 40);
    check("edge_dbl", 32'(cnt[2]), 32'd1);
    check("edge_noclick", 32'(cnt[3]), 32'd0);

    // one cycle later the gap has already timed out
    clear_cnt();
    run(1'b1, 8);
    run(1'b0, 21);
    run(1'b1, 8);
    run(1'b0, 40);
    check("late_click", 32'(cnt[3]), 32'd2);
    check("late_nodbl", 32'(cnt[2]), 32'd0);

    // reset while long-held, released with button up
    run(1'b1, 60);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    clear_cnt();
    run(1'b0, 40);
    check("rstlong_pulses", 32'(cnt[5] + cnt[4] + cnt[3] + cnt[2] + cnt[1] + cnt[0]), 32'd0);
    check("rstlong_outs", 32'(outs), 32'd0);

    // randomized level segments, including single-cycle glitches
    lv = 1'b0;
    for (int seg = 0; seg < 80; seg++) begin
      lv = ~lv;
      case ($urandom_range(0, 3))
        0:       dur = 1;
        1:       dur = $urandom_range(2, 30);
        2:       dur = $urandom_range(30, 60);
        default: dur = $urandom_range(60, 120);
      endcase
      run(lv, dur);
    end
    run(1'b0, 40);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_event.md
Name: btn_event

Overview:
- Consumer end of the debounced-button path: takes the clean level from the debouncer and decodes it into single-cycle user events.
- Events: press, release, single click, double click, long press, auto-repeat.
- Sits between the debouncer output and control FSMs (menu/mode logic), which then use pulses instead of levels.
- Input is from the slow debounce clock domain, so the block synchronizes it into `clk`.

Parameters:
- TICK_DIV, 100000, `clk` cycles per 1 ms timebase tick (100 MHz → 1 ms).
- LONG_MS, 1000, ms held before `long_p` fires.
- REPEAT_MS, 200, ms between `rpt_p` pulses after a long press.
- DCLICK_MS, 300, max ms from release to second press for a double click.
- CW, 16, width of the ms counter; must hold max(LONG_MS, REPEAT_MS, DCLICK_MS).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_ok  in  1  debounced button level from the debounce clock domain; 1 = pressed.
- held  out  1  synchronized button level.
- press_p  out  1  1-cycle pulse on press.
- release_p  out  1  1-cycle pulse on release.
- click_p  out  1  1-cycle pulse on a confirmed single short click.
- dbl_p  out  1  1-cycle pulse on a double click.
- long_p  out  1  1-cycle pulse when hold reaches LONG_MS.
- rpt_p  out  1  1-cycle auto-repeat pulse while long-held.

Behaviour:
- Reset (async, rst=1):
  - Sync flops, edge register, prescaler, ms counter and all outputs go to 0.
  - State goes to IDLE.
  - If `btn_ok`=1 when rst deasserts, this is treated as a fresh press: `press_p` fires 3 cycles later.
  - Reset mid-operation aborts any pending click/double/long without emitting a pulse.
- Synchronizer:
  - 2-FF on `btn_ok` gives s; `held`=s.
  - Edge register sp<=s.
  - rise = s&~sp; fall = ~s&sp.
- Latency:
  - All outputs are registered.
  - `press_p`/`release_p` assert for exactly 1 cycle, 3 rising `clk` edges after the `btn_ok` change.
- Timebase:
  - Prescaler counts 0..TICK_DIV-1 and wraps; tick=1 for the cycle prescaler==TICK_DIV-1.
  - On rise or fall, the prescaler and ms counter clear to 0.
  - ms counter increments on tick and saturates at all-ones (no wrap).
  - An edge in the same cycle as a tick wins: counter is 0 after that cycle.
- FSM states:
  - IDLE:
    - rise → PRESS; `press_p`.
  - PRESS:
    - fall → WAIT; `release_p`.
    - ms==LONG_MS on tick → LONG; `long_p`; repeat counter cleared.
  - LONG:
    - every REPEAT_MS ticks → `rpt_p`. The first `rpt_p` comes REPEAT_MS ms after `long_p`.
    - fall → IDLE; `release_p`; no click.
  - WAIT:
    - rise before ms reaches DCLICK_MS → PRESS2; `press_p` and `dbl_p` in the same cycle.
    - ms==DCLICK_MS on tick → IDLE; `click_p`.
  - PRESS2:
    - fall → IDLE; `release_p`; no click.
    - ms==LONG_MS → LONG; `long_p`. The second press may become a long press.
- Priority and exclusivity:
  - Within a state, an edge has priority over a timeout in the same cycle.
  - At most one of {`click_p`, `long_p`, `rpt_p`} per cycle.
  - `press_p` and `release_p` are never both high.
- Glitch tolerance: a 1-cycle pulse on s still produces a rise and a fall 1 cycle apart. Filtering is the debouncer's job.

Test Plan:
- Use TICK_DIV=4, LONG_MS=10, REPEAT_MS=3, DCLICK_MS=5 for all scenarios.
- rst=1 with `btn_ok`=1, then deassert → all outputs 0 during reset; `press_p` pulses 1 cycle, 3 cycles after deassert; `held`=1.
- Short click: press 8 ms, release, idle 10 ms → `press_p`, `release_p`, then `click_p` once, 5 ms (20 clk) after release; no `dbl_p`/`long_p`.
- Double click: press 2 ms, release 2 ms, press 2 ms, release → `dbl_p` coincident with the second `press_p`; no `click_p`; FSM back in IDLE.
- Long + repeat: hold 20 ms → `long_p` at 10 ms; `rpt_p` at 13, 16, 19 ms; release → `release_p`, no `click_p`.
- Release exactly on a tick cycle at ms==DCLICK_MS boundary in WAIT, with rise on the same cycle → `dbl_p`, not `click_p`.
- Assert rst in LONG while held; release rst with `btn_ok`=0 → no further pulses; all outputs 0.
